// File: rtl/ddr3_avl_arbiter.sv
// Read/write sequencer for the shared DDR3 Avalon-MM port: grants one engine at a time,
// registers the command onto the bus and holds a write grant for the whole burst.
module ddr3_avl_arbiter #(
  parameter int MAX_RD_RUN = 8,
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 128
) (
  input  logic              ddr3_clk,
  input  logic              ddr3_reset,
  input  logic              rd_req,
  input  logic              rd_urgent,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_size,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_size,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_beat_ack,
  output logic              wr_done,
  input  logic              ddr3_avl_ready,
  output logic              ddr3_avl_burstbegin,
  output logic [2:0]        ddr3_avl_size,
  output logic              ddr3_avl_read_req,
  output logic              ddr3_avl_write_req,
  output logic [ADDR_W-1:0] ddr3_avl_addr,
  output logic [DATA_W-1:0] ddr3_avl_wr_data
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_CMD   = 2'd1;
  localparam logic [1:0] ST_WR_BURST = 2'd2;

  localparam logic [7:0] RUN_MAX = 8'(MAX_RD_RUN);

  logic [1:0]        state_r;
  logic [7:0]        rd_run_r;
  logic [2:0]        beat_cnt_r;
  logic              read_req_r;
  logic              write_req_r;
  logic              burstbegin_r;
  logic [ADDR_W-1:0] addr_r;
  logic [2:0]        size_r;

  logic              grant_rd_s;
  logic              grant_wr_s;
  logic              run_sat_s;
  logic              rd_accept_s;
  logic              wr_accept_s;
  logic              last_beat_s;
  logic [2:0]        rd_size_eff_s;
  logic [2:0]        wr_size_eff_s;
  logic [7:0]        rd_run_inc_s;

  // A zero-length burst is issued as a single beat.
  assign rd_size_eff_s = (rd_size == 3'd0) ? 3'd1 : rd_size;
  assign wr_size_eff_s = (wr_size == 3'd0) ? 3'd1 : wr_size;

  assign run_sat_s    = (rd_run_r >= RUN_MAX);
  assign rd_run_inc_s = run_sat_s ? RUN_MAX : (rd_run_r + 8'd1);

  assign rd_accept_s = (state_r == ST_RD_CMD) && ddr3_avl_ready;
  assign wr_accept_s = (state_r == ST_WR_BURST) && ddr3_avl_ready;
  assign last_beat_s = (beat_cnt_r == (size_r - 3'd1));

  assign rd_ack      = rd_accept_s;
  assign wr_beat_ack = wr_accept_s;
  assign wr_done     = wr_accept_s && last_beat_s;

  assign ddr3_avl_read_req   = read_req_r;
  assign ddr3_avl_write_req  = write_req_r;
  assign ddr3_avl_burstbegin = burstbegin_r;
  assign ddr3_avl_addr       = addr_r;
  assign ddr3_avl_size       = size_r;
  assign ddr3_avl_wr_data    = wr_data;

  // Grant decision in IDLE: urgent read, starved write, read, write.
  always_comb begin
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (rd_req && rd_urgent) begin
        grant_rd_s = 1'b1;
      end else if (wr_req && run_sat_s) begin
        grant_wr_s = 1'b1;
      end else if (rd_req) begin
        grant_rd_s = 1'b1;
      end else if (wr_req) begin
        grant_wr_s = 1'b1;
      end else begin
        grant_rd_s = 1'b0;
        grant_wr_s = 1'b0;
      end
    end else begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
    end
  end

  // Command sequencer and registered Avalon command outputs.
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_reset) begin
      state_r      <= ST_IDLE;
      beat_cnt_r   <= 3'd0;
      read_req_r   <= 1'b0;
      write_req_r  <= 1'b0;
      burstbegin_r <= 1'b0;
      addr_r       <= '0;
      size_r       <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_rd_s) begin
            state_r      <= ST_RD_CMD;
            read_req_r   <= 1'b1;
            burstbegin_r <= 1'b1;
            addr_r       <= rd_addr;
            size_r       <= rd_size_eff_s;
          end else if (grant_wr_s) begin
            state_r      <= ST_WR_BURST;
            write_req_r  <= 1'b1;
            burstbegin_r <= 1'b1;
            beat_cnt_r   <= 3'd0;
            addr_r       <= wr_addr;
            size_r       <= wr_size_eff_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_CMD: begin
          if (ddr3_avl_ready) begin
            state_r      <= ST_IDLE;
            read_req_r   <= 1'b0;
            burstbegin_r <= 1'b0;
          end else begin
            state_r <= ST_RD_CMD;
          end
        end
        ST_WR_BURST: begin
          if (ddr3_avl_ready) begin
            burstbegin_r <= 1'b0;
            if (last_beat_s) begin
              state_r     <= ST_IDLE;
              write_req_r <= 1'b0;
              beat_cnt_r  <= 3'd0;
            end else begin
              beat_cnt_r <= beat_cnt_r + 3'd1;
            end
          end else begin
            state_r <= ST_WR_BURST;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          beat_cnt_r   <= 3'd0;
          read_req_r   <= 1'b0;
          write_req_r  <= 1'b0;
          burstbegin_r <= 1'b0;
        end
      endcase
    end
  end

  // Starvation guard: counts reads granted while a write waits, saturating.
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_reset) begin
      rd_run_r <= 8'd0;
    end else if (grant_wr_s) begin
      rd_run_r <= 8'd0;
    end else if (grant_rd_s) begin
      rd_run_r <= wr_req ? rd_run_inc_s : 8'd0;
    end else begin
      rd_run_r <= rd_run_r;
    end
  end

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Bench for ddr3_avl_arbiter: directed vector table, hand sequences for starvation,
// urgent override and mid-burst reset, then random traffic against a transaction model.
module tb_ddr3_avl_arbiter;

  localparam int MAXRUN = 3;
  localparam int AW = 26;
  localparam int DW = 128;

  logic          ddr3_clk;
  logic          ddr3_reset;
  logic          rd_req, rd_urgent, wr_req, ddr3_avl_ready;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [2:0]    rd_size, wr_size;
  logic [DW-1:0] wr_data;
  logic          rd_ack, wr_beat_ack, wr_done;
  logic          ddr3_avl_burstbegin, ddr3_avl_read_req, ddr3_avl_write_req;
  logic [2:0]    ddr3_avl_size;
  logic [AW-1:0] ddr3_avl_addr;
  logic [DW-1:0] ddr3_avl_wr_data;
  logic [5:0]    act_ctl;

  int n_checks = 0;
  int n_fail   = 0;

  ddr3_avl_arbiter #(.MAX_RD_RUN(MAXRUN), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ddr3_clk(ddr3_clk), .ddr3_reset(ddr3_reset),
    .rd_req(rd_req), .rd_urgent(rd_urgent), .rd_addr(rd_addr), .rd_size(rd_size), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
    .wr_beat_ack(wr_beat_ack), .wr_done(wr_done),
    .ddr3_avl_ready(ddr3_avl_ready), .ddr3_avl_burstbegin(ddr3_avl_burstbegin),
    .ddr3_avl_size(ddr3_avl_size), .ddr3_avl_read_req(ddr3_avl_read_req),
    .ddr3_avl_write_req(ddr3_avl_write_req), .ddr3_avl_addr(ddr3_avl_addr),
    .ddr3_avl_wr_data(ddr3_avl_wr_data)
  );

  // {read_req, write_req, burstbegin, rd_ack, wr_beat_ack, wr_done}
  assign act_ctl = {ddr3_avl_read_req, ddr3_avl_write_req, ddr3_avl_burstbegin,
                    rd_ack, wr_beat_ack, wr_done};

  initial ddr3_clk = 1'b0;
  always #5 ddr3_clk = ~ddr3_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          rd_req;
    logic          urg;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_size;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_size;
    logic [DW-1:0] wr_data;
    logic          ready;
    logic [5:0]    e_ctl;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_size;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got '%s' expected '%s'", nm, act, exp);
    end
  endtask

  task automatic add(input logic rq, input logic ug, input logic [AW-1:0] ra, input logic [2:0] rs,
                     input logic wq, input logic [AW-1:0] wa, input logic [2:0] ws,
                     input logic [DW-1:0] wd, input logic rdy, input logic [5:0] ec,
                     input logic [AW-1:0] ea, input logic [2:0] es);
    vec_t v;
    v.rd_req = rq; v.urg = ug; v.rd_addr = ra; v.rd_size = rs;
    v.wr_req = wq; v.wr_addr = wa; v.wr_size = ws; v.wr_data = wd; v.ready = rdy;
    v.e_ctl = ec; v.e_addr = ea; v.e_size = es;
    tbl.push_back(v);
  endtask

  // Transaction-level reference model state for the random phase.
  bit            m_busy, m_wr;
  logic [AW-1:0] m_addr;
  int            m_size, m_beat, m_run;

  localparam logic [AW-1:0] RA  = 26'h100;
  localparam logic [AW-1:0] WA  = 26'h2A0;
  localparam logic [DW-1:0] D0  = 128'hD0D0_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [DW-1:0] D1  = 128'hD1D1_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [DW-1:0] D2  = 128'hD2D2_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [DW-1:0] D3  = 128'hD3D3_0000_0000_0000_0000_0000_0000_0004;
  localparam logic [DW-1:0] DZ  = 128'h0;
  localparam logic [AW-1:0] AZ  = 26'h0;

  initial begin
    string seq;
    int guard;
    int beats;
    bit saw_rd_ack, saw_beat, saw_done, rd_pend, wr_pend;
    int g;
    bit e_rd, e_wr, e_bb, e_ra, e_wb, e_dn;

    // Reset with requests active: nothing may be granted, wr_data passes through.
    ddr3_reset = 1'b1; rd_req = 1'b1; rd_urgent = 1'b0; rd_addr = RA; rd_size = 3'd4;
    wr_req = 1'b1; wr_addr = WA; wr_size = 3'd4; wr_data = 128'hCAFE; ddr3_avl_ready = 1'b1;
    repeat (3) @(posedge ddr3_clk);
    @(negedge ddr3_clk);
    chk("reset_ctl", 160'(act_ctl), 160'(6'b000000));
    chk("reset_wr_data", 160'(ddr3_avl_wr_data), 160'(128'hCAFE));
    @(posedge ddr3_clk); #1;
    ddr3_reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0; wr_data = DZ;

    // Directed vectors, one row per cycle; expected outputs reflect state after the prior edge.
    add(1'b1,1'b0,RA,3'd4,      1'b0,AZ,3'd0,DZ, 1'b1, 6'b000000, AZ,3'd0);
    add(1'b1,1'b0,RA,3'd4,      1'b0,AZ,3'd0,DZ, 1'b1, 6'b101100, RA,3'd4);
    add(1'b0,1'b0,AZ,3'd0,      1'b0,AZ,3'd0,DZ, 1'b1, 6'b000000, AZ,3'd0);
    add(1'b0,1'b0,AZ,3'd0,      1'b0,AZ,3'd0,DZ, 1'b1, 6'b000000, AZ,3'd0);
    add(1'b1,1'b0,26'h3,3'd0,   1'b0,AZ,3'd0,DZ, 1'b1, 6'b000000, AZ,3'd0);
    add(1'b1,1'b0,26'h3,3'd0,   1'b0,AZ,3'd0,DZ, 1'b0, 6'b101000, 26'h3,3'd1);
    add(1'b1,1'b0,26'h3,3'd0,   1'b0,AZ,3'd0,DZ, 1'b1, 6'b101100, 26'h3,3'd1);
    add(1'b0,1'b0,AZ,3'd0,      1'b0,AZ,3'd0,DZ, 1'b1, 6'b000000, AZ,3'd0);
    add(1'b0,1'b0,AZ,3'd0,      1'b1,WA,3'd4,D0, 1'b1, 6'b000000, AZ,3'd0);
    add(1'b0,1'b0,AZ,3'd0,      1'b1,WA,3'd4,D0, 1'b1, 6'b011010, WA,3'd4);
    add(1'b0,1'b0,AZ,3'd0,      1'b1,WA,3'd4,D1, 1'b0, 6'b010000, WA,3'd4);
    add(1'b0,1'b0,AZ,3'd0,      1'b0,WA,3'd4,D1, 1'b1, 6'b010010, WA,3'd4);
    add(1'b0,1'b0,AZ,3'd0,      1'b0,WA,3'd4,D2, 1'b1, 6'b010010, WA,3'd4);
    add(1'b0,1'b0,AZ,3'd0,      1'b0,WA,3'd4,D3, 1'b0, 6'b010000, WA,3'd4);
    add(1'b0,1'b0,AZ,3'd0,      1'b0,WA,3'd4,D3, 1'b1, 6'b010011, WA,3'd4);
    add(1'b0,1'b0,AZ,3'd0,      1'b0,AZ,3'd0,DZ, 1'b1, 6'b000000, AZ,3'd0);
    add(1'b1,1'b0,26'h44,3'd2,  1'b1,26'h55,3'd1,D0, 1'b1, 6'b000000, AZ,3'd0);
    add(1'b1,1'b0,26'h44,3'd2,  1'b1,26'h55,3'd1,D0, 1'b1, 6'b101100, 26'h44,3'd2);
    add(1'b0,1'b0,AZ,3'd0,      1'b1,26'h55,3'd1,D0, 1'b1, 6'b000000, AZ,3'd0);
    add(1'b0,1'b0,AZ,3'd0,      1'b1,26'h55,3'd1,D0, 1'b1, 6'b011011, 26'h55,3'd1);
    add(1'b0,1'b0,AZ,3'd0,      1'b0,AZ,3'd0,DZ, 1'b1, 6'b000000, AZ,3'd0);

    foreach (tbl[i]) begin
      @(posedge ddr3_clk); #1;
      rd_req = tbl[i].rd_req; rd_urgent = tbl[i].urg; rd_addr = tbl[i].rd_addr; rd_size = tbl[i].rd_size;
      wr_req = tbl[i].wr_req; wr_addr = tbl[i].wr_addr; wr_size = tbl[i].wr_size;
      wr_data = tbl[i].wr_data; ddr3_avl_ready = tbl[i].ready;
      @(negedge ddr3_clk);
      chk($sformatf("vec%0d_ctl", i), 160'(act_ctl), 160'(tbl[i].e_ctl));
      if (tbl[i].e_ctl[5] || tbl[i].e_ctl[4])
        chk($sformatf("vec%0d_addr_size", i), 160'({ddr3_avl_addr, ddr3_avl_size}),
            160'({tbl[i].e_addr, tbl[i].e_size}));
      chk($sformatf("vec%0d_wr_data", i), 160'(ddr3_avl_wr_data), 160'(tbl[i].wr_data));
    end

    // Starvation guard: continuous reads and writes, no urgent.
    rd_req = 1'b1; wr_req = 1'b1; rd_size = 3'd1; wr_size = 3'd1; rd_urgent = 1'b0;
    ddr3_avl_ready = 1'b1; rd_addr = 26'h10; wr_addr = 26'h20;
    seq = ""; guard = 0;
    while (seq.len() < 8 && guard < 100) begin
      @(negedge ddr3_clk); guard++;
      if (ddr3_avl_read_req) seq = {seq, "R"};
      else if (ddr3_avl_write_req) seq = {seq, "W"};
    end
    chk_str("starvation_grants", seq, "RRRWRRRW");

    // Urgent override, then drop urgent once rd_run is saturated.
    rd_urgent = 1'b1;
    seq = ""; guard = 0;
    while (seq.len() < 7 && guard < 100) begin
      @(negedge ddr3_clk); guard++;
      if (ddr3_avl_read_req) seq = {seq, "R"};
      else if (ddr3_avl_write_req) seq = {seq, "W"};
      if (seq.len() == 6) rd_urgent = 1'b0;
    end
    chk_str("urgent_grants", seq, "RRRRRRW");
    rd_req = 1'b0; wr_req = 1'b0; rd_urgent = 1'b0;
    repeat (2) @(negedge ddr3_clk);

    // Reset while beat 2 of a 4-beat write is on the bus.
    wr_req = 1'b1; wr_size = 3'd4; wr_addr = 26'h300; ddr3_avl_ready = 1'b1;
    beats = 0; guard = 0;
    while (beats < 2 && guard < 50) begin
      @(negedge ddr3_clk); guard++;
      if (wr_beat_ack) beats++;
    end
    @(negedge ddr3_clk);
    chk("mid_burst_beat2", 160'(act_ctl), 160'(6'b010010));
    ddr3_reset = 1'b1; wr_req = 1'b0;
    @(negedge ddr3_clk);
    chk("mid_burst_reset_ctl", 160'(act_ctl), 160'(6'b000000));
    ddr3_reset = 1'b0; rd_req = 1'b1; rd_addr = 26'h77; rd_size = 3'd2;
    @(negedge ddr3_clk);
    chk("post_reset_read_ctl", 160'(act_ctl), 160'(6'b101100));
    chk("post_reset_read_addr", 160'({ddr3_avl_addr, ddr3_avl_size}), 160'({26'h77, 3'd2}));
    rd_req = 1'b0;
    @(negedge ddr3_clk);
    chk("post_reset_idle", 160'(act_ctl), 160'(6'b000000));

    // Random traffic against the reference model.
    ddr3_reset = 1'b1;
    @(negedge ddr3_clk);
    ddr3_reset = 1'b0;
    m_busy = 1'b0; m_wr = 1'b0; m_addr = '0; m_size = 0; m_beat = 0; m_run = 0;
    saw_rd_ack = 1'b0; saw_beat = 1'b0; saw_done = 1'b0; rd_pend = 1'b0; wr_pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge ddr3_clk);
      if (m_busy) begin
        if (ddr3_avl_ready) begin
          if (!m_wr) m_busy = 1'b0;
          else begin
            m_beat++;
            if (m_beat == m_size) m_busy = 1'b0;
          end
        end
      end else begin
        if (rd_req && rd_urgent) g = 1;
        else if (wr_req && m_run == MAXRUN) g = 2;
        else if (rd_req) g = 1;
        else if (wr_req) g = 2;
        else g = 0;
        if (g == 1) begin
          m_busy = 1'b1; m_wr = 1'b0; m_addr = rd_addr;
          m_size = (rd_size == 3'd0) ? 1 : int'(rd_size);
          m_run = wr_req ? ((m_run + 1 > MAXRUN) ? MAXRUN : m_run + 1) : 0;
        end else if (g == 2) begin
          m_busy = 1'b1; m_wr = 1'b1; m_addr = wr_addr; m_beat = 0;
          m_size = (wr_size == 3'd0) ? 1 : int'(wr_size);
          m_run = 0;
        end
      end
      #1;
      if (saw_rd_ack) rd_pend = 1'b0;
      if (!rd_pend && ($urandom_range(0, 2) == 0)) begin
        rd_pend = 1'b1; rd_addr = AW'($urandom()); rd_size = 3'($urandom_range(0, 7));
      end
      rd_req = rd_pend;
      if (saw_done) wr_pend = 1'b0;
      if (saw_beat) wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (!wr_pend && ($urandom_range(0, 2) == 0)) begin
        wr_pend = 1'b1; wr_addr = AW'($urandom()); wr_size = 3'($urandom_range(0, 7));
        wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      wr_req = wr_pend;
      ddr3_avl_ready = ($urandom_range(0, 3) != 0);
      rd_urgent = ($urandom_range(0, 3) == 0);
      @(negedge ddr3_clk);
      e_rd = m_busy && !m_wr;
      e_wr = m_busy && m_wr;
      e_bb = m_busy && (!m_wr || m_beat == 0);
      e_ra = e_rd && ddr3_avl_ready;
      e_wb = e_wr && ddr3_avl_ready;
      e_dn = e_wb && (m_beat == m_size - 1);
      chk($sformatf("rand%0d_ctl", cyc), 160'(act_ctl), 160'({e_rd, e_wr, e_bb, e_ra, e_wb, e_dn}));
      if (m_busy)
        chk($sformatf("rand%0d_addr_size", cyc), 160'({ddr3_avl_addr, ddr3_avl_size}),
            160'({m_addr, 3'(m_size)}));
      if (cyc % 16 == 0)
        chk($sformatf("rand%0d_wr_data", cyc), 160'(ddr3_avl_wr_data), 160'(wr_data));
      saw_rd_ack = e_ra;
      saw_beat = e_wb;
      saw_done = e_dn;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
